// File: rtl/ctrl_time_seq.sv
// Timed step sequencer: a shadow event table is validated and latched into the
// active table on start, then a free-running step counter sweeps 0..period-1.
module ctrl_time_seq #(
  parameter int               CNT_W = 12,
  parameter int               VAL_W = 64,
  parameter logic [CNT_W-1:0] PARK  = 12'hFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_time,
  input  logic [VAL_W-1:0] cfg_value,
  input  logic             start,
  input  logic             stop,
  output logic             sta,
  output logic [CNT_W-1:0] counter,
  output logic [CNT_W-1:0] time_1,
  output logic [CNT_W-1:0] time_2,
  output logic [CNT_W-1:0] time_3,
  output logic [CNT_W-1:0] time_4,
  output logic [CNT_W-1:0] time_5,
  output logic [CNT_W-1:0] time_6,
  output logic [CNT_W-1:0] time_7,
  output logic [VAL_W-1:0] value_1,
  output logic [VAL_W-1:0] value_2,
  output logic [VAL_W-1:0] value_3,
  output logic [VAL_W-1:0] value_4,
  output logic [VAL_W-1:0] value_5,
  output logic [VAL_W-1:0] value_6,
  output logic [VAL_W-1:0] value_7,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  localparam logic [1:0]       S_IDLE     = 2'd0;
  localparam logic [1:0]       S_ARM      = 2'd1;
  localparam logic [1:0]       S_RUN      = 2'd2;
  localparam logic [1:0]       S_DONE     = 2'd3;
  localparam logic [CNT_W-1:0] T_UNUSED   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MAX_PERIOD = CNT_W'(4094);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO       = {CNT_W{1'b0}};
  localparam logic [VAL_W-1:0] V_ZERO     = {VAL_W{1'b0}};

  logic [1:0]       r_state;
  logic             r_sta;
  logic [CNT_W-1:0] r_counter;
  logic             r_busy;
  logic             r_done;
  logic             r_cfg_err;
  logic [CNT_W-1:0] r_sh_period;
  logic [2:0]       r_sh_num;
  logic [CNT_W-1:0] r_sh_time  [1:7];
  logic [VAL_W-1:0] r_sh_value [1:7];
  logic [CNT_W-1:0] r_ac_period;
  logic [CNT_W-1:0] r_time     [1:7];
  logic [VAL_W-1:0] r_value    [1:7];
  logic             w_sh_valid;
  logic             w_last;
  logic [CNT_W-1:0] w_prev;

  // Shadow table validity; w_prev starting at zero also enforces time_k >= 1.
  always_comb begin
    w_prev     = ZERO;
    w_sh_valid = (r_sh_period != ZERO) && (r_sh_period <= MAX_PERIOD);
    for (int k = 1; k < 8; k++) begin
      if (3'(k) <= r_sh_num) begin
        w_sh_valid = w_sh_valid && (r_sh_time[k] > w_prev) && (r_sh_time[k] <= r_sh_period);
        w_prev     = r_sh_time[k];
      end else begin
        w_sh_valid = w_sh_valid;
      end
    end
  end

  assign w_last = (r_counter == (r_ac_period - ONE));

  // Shadow table writes; never touch the active table.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sh_period <= ZERO;
      r_sh_num    <= 3'd0;
      for (int k = 1; k < 8; k++) begin
        r_sh_time[k]  <= T_UNUSED;
        r_sh_value[k] <= V_ZERO;
      end
    end else if (cfg_we) begin
      if (cfg_addr == 3'd0) begin
        r_sh_period <= cfg_time;
        r_sh_num    <= cfg_value[2:0];
      end else begin
        r_sh_time[cfg_addr]  <= cfg_time;
        r_sh_value[cfg_addr] <= cfg_value;
      end
    end else begin
      r_sh_period <= r_sh_period;
    end
  end

  // Sequencer state, control outputs and active table capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sta       <= 1'b1;
      r_counter   <= PARK;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_ac_period <= ZERO;
      for (int k = 1; k < 8; k++) begin
        r_time[k]  <= T_UNUSED;
        r_value[k] <= V_ZERO;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          r_sta     <= 1'b0;
          r_counter <= PARK;
          if (start && !stop) begin
            if (w_sh_valid) begin
              r_state     <= S_ARM;
              r_sta       <= 1'b1;
              r_busy      <= 1'b1;
              r_cfg_err   <= 1'b0;
              r_ac_period <= r_sh_period;
              // Unused events are parked outside any reachable counter value.
              for (int k = 1; k < 8; k++) begin
                r_time[k]  <= (3'(k) <= r_sh_num) ? r_sh_time[k] : T_UNUSED;
                r_value[k] <= (3'(k) <= r_sh_num) ? r_sh_value[k] : V_ZERO;
              end
            end else begin
              r_cfg_err <= 1'b1;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ARM: begin
          if (stop) begin
            r_state   <= S_IDLE;
            r_sta     <= 1'b1;
            r_busy    <= 1'b0;
            r_counter <= PARK;
          end else begin
            r_state   <= S_RUN;
            r_sta     <= 1'b0;
            r_counter <= ZERO;
          end
        end
        S_RUN: begin
          if (stop) begin
            r_state   <= S_IDLE;
            r_sta     <= 1'b1;
            r_busy    <= 1'b0;
            r_counter <= PARK;
          end else if (w_last) begin
            r_state   <= S_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_counter <= PARK;
          end else begin
            r_counter <= r_counter + ONE;
          end
        end
        S_DONE: begin
          r_state   <= S_IDLE;
          r_done    <= 1'b0;
          r_counter <= PARK;
        end
        default: begin
          r_state   <= S_IDLE;
          r_sta     <= 1'b0;
          r_busy    <= 1'b0;
          r_done    <= 1'b0;
          r_counter <= PARK;
        end
      endcase
    end
  end

  assign sta     = r_sta;
  assign counter = r_counter;
  assign busy    = r_busy;
  assign done    = r_done;
  assign cfg_err = r_cfg_err;
  assign time_1  = r_time[1];
  assign time_2  = r_time[2];
  assign time_3  = r_time[3];
  assign time_4  = r_time[4];
  assign time_5  = r_time[5];
  assign time_6  = r_time[6];
  assign time_7  = r_time[7];
  assign value_1 = r_value[1];
  assign value_2 = r_value[2];
  assign value_3 = r_value[3];
  assign value_4 = r_value[4];
  assign value_5 = r_value[5];
  assign value_6 = r_value[6];
  assign value_7 = r_value[7];

endmodule

// File: tb/tb_ctrl_time_seq.sv
// Bench for ctrl_time_seq: directed scenarios plus random traffic, every cycle
// compared against a phase-counting reference model of the sequencer.
module tb_ctrl_time_seq;

  logic        clk = 1'b0;
  logic        rst_n, cfg_we, start, stop;
  logic [2:0]  cfg_addr;
  logic [11:0] cfg_time;
  logic [63:0] cfg_value;
  logic        sta, busy, done, cfg_err;
  logic [11:0] counter;
  logic [11:0] time_1, time_2, time_3, time_4, time_5, time_6, time_7;
  logic [63:0] value_1, value_2, value_3, value_4, value_5, value_6, value_7;
  logic [11:0] t_out [1:7];
  logic [63:0] v_out [1:7];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase -1 idle, 0 arm, 1..period run (counter=phase-1), period+1 done.
  int          m_phase;
  bit          m_sta, m_err;
  int          s_period, s_num, a_period, a_num;
  int          s_time [1:7];
  int          a_time [1:7];
  logic [63:0] s_val  [1:7];
  logic [63:0] a_val  [1:7];

  ctrl_time_seq dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_time(cfg_time), .cfg_value(cfg_value), .start(start), .stop(stop),
    .sta(sta), .counter(counter),
    .time_1(time_1), .time_2(time_2), .time_3(time_3), .time_4(time_4),
    .time_5(time_5), .time_6(time_6), .time_7(time_7),
    .value_1(value_1), .value_2(value_2), .value_3(value_3), .value_4(value_4),
    .value_5(value_5), .value_6(value_6), .value_7(value_7),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  assign t_out[1] = time_1;  assign t_out[2] = time_2;  assign t_out[3] = time_3;
  assign t_out[4] = time_4;  assign t_out[5] = time_5;  assign t_out[6] = time_6;
  assign t_out[7] = time_7;
  assign v_out[1] = value_1; assign v_out[2] = value_2; assign v_out[3] = value_3;
  assign v_out[4] = value_4; assign v_out[5] = value_5; assign v_out[6] = value_6;
  assign v_out[7] = value_7;

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit tbl_ok();
    if (s_period < 1 || s_period > 4094) return 1'b0;
    for (int k = 1; k <= s_num; k++) begin
      if (s_time[k] < 1 || s_time[k] > s_period) return 1'b0;
      if (k > 1 && s_time[k] <= s_time[k-1]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_step(input bit we, input int addr, input int tm, input logic [63:0] val,
                            input bit st, input bit sp, input bit rn);
    bit ok;
    if (!rn) begin
      m_phase = -1; m_sta = 1'b1; m_err = 1'b0;
      s_period = 0; s_num = 0; a_period = 0; a_num = 0;
      for (int k = 1; k <= 7; k++) begin
        s_time[k] = 4095; a_time[k] = 4095; s_val[k] = '0; a_val[k] = '0;
      end
      return;
    end
    ok = tbl_ok();
    if (m_phase == -1) begin
      m_sta = 1'b0;
      if (st && !sp) begin
        if (ok) begin
          m_phase = 0; m_sta = 1'b1; m_err = 1'b0;
          a_period = s_period; a_num = s_num; a_time = s_time; a_val = s_val;
        end else begin
          m_err = 1'b1;
        end
      end
    end else if (m_phase <= a_period) begin
      if (sp) begin
        m_phase = -1; m_sta = 1'b1;
      end else begin
        m_sta = 1'b0;
        m_phase++;
      end
    end else begin
      m_phase = -1; m_sta = 1'b0;
    end
    if (we) begin
      if (addr == 0) begin
        s_period = tm; s_num = int'(val[2:0]);
      end else begin
        s_time[addr] = tm; s_val[addr] = val;
      end
    end
  endtask

  task automatic check_all();
    int exp_cnt;
    exp_cnt = (m_phase >= 1 && m_phase <= a_period) ? m_phase - 1 : 4095;
    check_eq("sta", 64'(sta), 64'(m_sta));
    check_eq("counter", 64'(counter), 64'(exp_cnt));
    check_eq("busy", 64'(busy), 64'(m_phase >= 0 && m_phase <= a_period));
    check_eq("done", 64'(done), 64'(m_phase == a_period + 1));
    check_eq("cfg_err", 64'(cfg_err), 64'(m_err));
    for (int k = 1; k <= 7; k++) begin
      check_eq($sformatf("time_%0d", k), 64'(t_out[k]), 64'((k <= a_num) ? a_time[k] : 4095));
      check_eq($sformatf("value_%0d", k), v_out[k], (k <= a_num) ? a_val[k] : 64'd0);
    end
  endtask

  task automatic cycle(input bit we, input bit [2:0] addr, input bit [11:0] tm,
                       input bit [63:0] val, input bit st, input bit sp, input bit rn);
    cfg_we = we; cfg_addr = addr; cfg_time = tm; cfg_value = val;
    start = st; stop = sp; rst_n = rn;
    @(posedge clk);
    #1;
    model_step(we, int'(addr), int'(tm), val, st, sp, rn);
    check_all();
  endtask

  task automatic idle();
    cycle(1'b0, 3'd0, 12'd0, 64'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic wr(input bit [2:0] addr, input bit [11:0] tm, input bit [63:0] val);
    cycle(1'b1, addr, tm, val, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic go();
    cycle(1'b0, 3'd0, 12'd0, 64'd0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic halt();
    cycle(1'b0, 3'd0, 12'd0, 64'd0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic load_2_5_8();
    wr(3'd0, 12'd10, 64'd3);
    wr(3'd1, 12'd2, 64'hA1);
    wr(3'd2, 12'd5, 64'hB2);
    wr(3'd3, 12'd8, 64'hC3);
  endtask

  task automatic run_to(input int target, input string tag);
    for (int i = 0; i < 40 && int'(counter) != target; i++) idle();
    check_eq(tag, 64'(counter), 64'(target));
  endtask

  // Random table that is valid by construction; unused slots get junk.
  task automatic rand_tbl();
    int per, n, t;
    per = $urandom_range(1, 30);
    n   = $urandom_range(0, 7);
    if (n > per) n = per;
    wr(3'd0, 12'(per), {$urandom, 29'($urandom), 3'(n)});
    t = 0;
    for (int k = 1; k <= 7; k++) begin
      if (k <= n) t = $urandom_range(t + 1, per - (n - k));
      else        t = $urandom_range(0, 40);
      wr(3'(k), 12'(t), {$urandom, $urandom});
    end
  endtask

  initial begin
    int bc;
    cycle(1'b0, 3'd0, 12'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 3'd0, 12'd0, 64'd0, 1'b1, 1'b0, 1'b0);
    check_eq("rst_sta", 64'(sta), 64'd1);
    check_eq("rst_counter", 64'(counter), 64'hFFF);
    idle();
    check_eq("rel_sta", 64'(sta), 64'd0);

    // Normal run
    load_2_5_8();
    go();
    check_eq("arm_sta", 64'(sta), 64'd1);
    check_eq("arm_counter", 64'(counter), 64'hFFF);
    bc = int'(busy);
    for (int i = 0; i < 11; i++) begin
      idle();
      bc += int'(busy);
    end
    check_eq("done_pulse", 64'(done), 64'd1);
    check_eq("done_counter", 64'(counter), 64'hFFF);
    check_eq("busy_len", 64'(bc), 64'd11);
    idle();

    // Invalid table then recovery
    wr(3'd1, 12'd4, 64'h11);
    wr(3'd2, 12'd4, 64'h22);
    go();
    check_eq("inv_err", 64'(cfg_err), 64'd1);
    check_eq("inv_busy", 64'(busy), 64'd0);
    wr(3'd2, 12'd5, 64'h22);
    go();
    check_eq("rec_err", 64'(cfg_err), 64'd0);

    // Abort at counter 6
    run_to(6, "reach_cnt6");
    halt();
    check_eq("abort_sta", 64'(sta), 64'd1);
    check_eq("abort_counter", 64'(counter), 64'hFFF);
    repeat (4) idle();

    // Start/stop collision, then period=0 table
    cycle(1'b0, 3'd0, 12'd0, 64'd0, 1'b1, 1'b1, 1'b1);
    check_eq("coll_busy", 64'(busy), 64'd0);
    wr(3'd0, 12'd0, 64'd3);
    go();
    check_eq("per0_err", 64'(cfg_err), 64'd1);

    // Shadow isolation during RUN
    load_2_5_8();
    go();
    idle(); idle();
    wr(3'd1, 12'd7, 64'h77);
    check_eq("iso_time1", 64'(time_1), 64'd2);
    repeat (12) idle();
    wr(3'd2, 12'd8, 64'h88);
    wr(3'd3, 12'd9, 64'h99);
    go();
    check_eq("iso_new_time1", 64'(time_1), 64'd7);

    // Reset mid-run at counter 3
    run_to(3, "reach_cnt3");
    cycle(1'b0, 3'd0, 12'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    check_eq("mrst_sta", 64'(sta), 64'd1);
    check_eq("mrst_counter", 64'(counter), 64'hFFF);
    check_eq("mrst_time1", 64'(time_1), 64'hFFF);
    check_eq("mrst_value1", value_1, 64'd0);
    idle();
    check_eq("mrst_rel_sta", 64'(sta), 64'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 999);
      if (r < 6) begin
        cycle(1'b0, 3'd0, 12'd0, 64'd0, 1'b0, 1'b0, 1'b0);
      end else if (r < 30) begin
        rand_tbl();
      end else begin
        cycle($urandom_range(0, 9) == 0, 3'($urandom_range(0, 7)), 12'($urandom_range(0, 24)),
              {$urandom, $urandom}, $urandom_range(0, 14) == 0, $urandom_range(0, 49) == 0, 1'b1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_time_seq.md
CTRL_TIME_SEQ -- requirements
Module: ctrl_time_seq

Interface
REQ-001 SHALL have parameters: CNT_W, default 12, counter/time width; VAL_W, default `EXTENDED_SINGLE (64), value width; PARK, default 12'hFFF, idle counter value.
REQ-002 SHALL have ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- cfg_we  in  1  shadow-table write strobe.
- cfg_addr  in  3  0 = period/num_ev; 1..7 = event k.
- cfg_time  in  CNT_W  period (addr 0) or time_k.
- cfg_value  in  VAL_W  value_k; at addr 0, bits [2:0] = num_ev.
- start  in  1  run request pulse.
- stop  in  1  abort request pulse.
- sta  out  1  downstream clear pulse.
- counter  out  CNT_W  step counter.
- time_1..time_7  out  CNT_W each  active event times.
- value_1..value_7  out  VAL_W each  active event values.
- busy  out  1  high in ARM and RUN.
- done  out  1  one-cycle pulse on normal completion.
- cfg_err  out  1  sticky start-rejected flag.

Function
REQ-003 SHALL hold a shadow table (period, num_ev, time_k, value_k) that is writable on any cycle with cfg_we=1; writes SHALL never alter the active table.
REQ-004 SHALL implement states IDLE, ARM, RUN, DONE; all outputs registered.
REQ-005 A start is accepted only in IDLE when the shadow table is valid: 1<=period<=4094; num_ev<=7; for k<=num_ev, 1<=time_k<=period; time_k strictly increasing in k.
REQ-006 Accepted start: next cycle ARM; shadow copied to active; sta=1; counter=PARK; cfg_err cleared.
REQ-007 Rejected start (invalid table): stay IDLE; cfg_err=1 next cycle; sta, counter unchanged.
REQ-008 ARM -> RUN after exactly one cycle; first RUN cycle: counter=0, sta=0.
REQ-009 In RUN, counter SHALL increment by 1 every clock, never hold, never wrap.
REQ-010 When counter==period-1 in RUN: next cycle DONE, counter=PARK, done=1.
REQ-011 DONE -> IDLE after one cycle; done=0 in every state except DONE.
REQ-012 In IDLE and DONE, counter SHALL equal PARK.
REQ-013 time_k output = active time_k for k<=active num_ev, else 12'hFFF; value_k output = active value_k, else 0.
REQ-014 No time_k output minus 1 SHALL equal PARK or any counter value outside 0..period-1 of an unused event (guaranteed by REQ-005 and REQ-013).
REQ-015 stop in ARM or RUN: next cycle IDLE; sta=1 for one cycle; counter=PARK; done stays 0; active table retained.
REQ-016 stop in IDLE or DONE: ignored. stop and start in the same cycle: stop wins; start is discarded.
REQ-017 start in ARM, RUN or DONE: ignored; cfg_err is not affected.
REQ-018 busy=1 exactly in ARM and RUN.

Reset
REQ-019 rst_n=0 at a clock edge, in any state including mid-RUN: state=IDLE; sta=1; counter=PARK; busy=0; done=0; cfg_err=0.
REQ-020 Reset values for both tables: period=0, num_ev=0, times=12'hFFF, values=0.
REQ-021 sta SHALL fall to 0 on the first edge with rst_n=1.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Run: period=10, num_ev=3, times 2/5/8, then start -> ARM: sta=1; then counter 0..9 on consecutive cycles; then done=1 with counter=FFF; busy high for 11 cycles.
- Invalid table: time_2=time_1=4, then start -> no ARM; cfg_err=1; next valid start clears it.
- Abort: stop at counter=6 -> next cycle IDLE, sta=1, counter=FFF, done never asserted.
- Collision: start and stop in the same IDLE cycle -> remains IDLE; start with a period=0 table -> cfg_err=1.
- Shadow isolation: rewrite time_1=7 during RUN -> time_1 output unchanged until the next accepted start.
- Reset mid-RUN at counter=3 -> next cycle sta=1, counter=FFF, time_k=FFF, value_k=0; sta=0 one cycle after release.
